poly_eval_driver: RTL and testbench
===================================

Name: poly_eval_driver

Overview:
- Initiator for the Go/DataIn/ResultValid operand-load protocol of the quadratic evaluator, which computes A*x^2 + B*x + C mod 256.
- Accepts one four-operand request from a host-side valid/ready port.
- Serialises A, B, C, X onto DataIn with a press/release Go sequence, then waits for ResultValid.
- Returns the captured DataResult to the host, or flags a timeout.

Parameters:
- GO_HI_CYCLES, 2, cycles Go is held high per operand (>=1).
- GO_LO_CYCLES, 2, cycles Go is held low after each operand (>=1).
- TIMEOUT, 32, max cycles in WAIT_RES before abort (>=8).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  driver can accept a request.
- req_a, req_b, req_c, req_x  in  8 each  operands.
- DataIn  out  8  operand to evaluator.
- Go  out  1  evaluator go strobe.
- DataResult  in  8  evaluator result.
- ResultValid  in  1  evaluator result valid (level).
- rsp_valid  out  1  one-cycle pulse: rsp_data is valid.
- rsp_data  out  8  captured result, held until next capture.
- rsp_timeout  out  1  one-cycle pulse: transaction aborted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (Reset=0, async): state IDLE; Go=0, DataIn=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0; operand regs, counters and index cleared.
- Reset mid-transaction: Go drops immediately. The evaluator is not resynchronised by this block, so integration must reset both together.
- States: IDLE, DRIVE_HI, DRIVE_LO, WAIT_RES.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch the four operands, set idx=0 and go to DRIVE_HI.
  - req_ready is 0 in every other state.
- DRIVE_HI:
  - DataIn = operand[idx] (order A, B, C, X).
  - Go=1 for exactly GO_HI_CYCLES cycles, then go to DRIVE_LO.
  - DataIn is valid from the first Go=1 cycle, because the evaluator samples DataIn on the edge where it first sees Go.
- DRIVE_LO:
  - Go=0 for exactly GO_LO_CYCLES cycles; DataIn keeps operand[idx].
  - Then if idx==3 go to WAIT_RES with the timeout counter cleared; else idx++ and go to DRIVE_HI.
- WAIT_RES:
  - Go=0; the counter increments each cycle.
  - First cycle with ResultValid=1: rsp_data<=DataResult, rsp_valid pulses in the following cycle, state goes to IDLE.
  - If the counter reaches TIMEOUT-1 with ResultValid=0: rsp_timeout pulses, rsp_data unchanged, state goes to IDLE.
  - ResultValid and timeout in the same cycle: ResultValid wins.
- Go and DataIn are registered outputs (no combinational path from inputs).
- Stale ResultValid held from a previous transaction is ignored outside WAIT_RES. The evaluator leaves its valid state on the first Go of the A operand, so ResultValid is low before WAIT_RES.
- Latency: request accept to rsp_valid = 4*(GO_HI_CYCLES+GO_LO_CYCLES) + evaluator compute (6) + capture (~2) cycles. With default parameters this is about 24 cycles, fixed.
- A new request is accepted the cycle after rsp_valid/rsp_timeout, since IDLE asserts req_ready.
- Counters are sized to $clog2 of the largest parameter plus 1, with no wrap before terminal count.

Optional Feature:
- Macro: POLY_EVAL_DRIVER_CHECK_EN.
- With it defined:
  - An internal reference model computes (a*x*x + b*x + c) mod 256 from the latched operands.
  - Extra output port chk_err (1 bit) pulses together with rsp_valid when rsp_data differs from the model; reset value 0.
- Without it: no chk_err port and no multiplier logic.

Decomposition:
- Shared package: state encoding localparams (IDLE, DRIVE_HI, DRIVE_LO, WAIT_RES), operand index constants (IDX_A=0 .. IDX_X=3), and the 8-bit data width constant.
- One natural sub-module: poly_eval_ref_model, the combinational mod-256 quadratic used only under POLY_EVAL_DRIVER_CHECK_EN.
- Counters and FSM stay in the top block.

Test Plan:
- Connect to the evaluator, request a=1 b=2 c=3 x=4 -> Go shows 4 pulses of 2 cycles each with DataIn 1,2,3,4; rsp_valid once; rsp_data=27 (0x1B).
- a=3 b=5 c=7 x=10 -> rsp_data=101 (357 mod 256); with CHECK_EN, chk_err stays 0.
- Stub evaluator holding ResultValid=0 -> rsp_timeout pulses 32 cycles after WAIT_RES entry, rsp_valid never asserts, req_ready=1 next cycle.
- Two back-to-back requests (1,2,3,4) then (0,0,5,9) with req_valid held -> second accepted the cycle after the first rsp_valid; results 27 then 5.
- Assert Reset low during the DRIVE_HI of operand C -> Go=0, DataIn=0 and busy=0 asynchronously; after release the next request completes correctly (both blocks reset).
- Stub returning DataResult=0xFF for inputs 1,2,3,4 with CHECK_EN -> chk_err=1 coincident with rsp_valid.

Source files
------------

// File: rtl/poly_eval_driver_pkg.sv
// Shared types and constants for the quadratic evaluator driver.
package poly_eval_driver_pkg;

   localparam int DATA_W = 8;
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   localparam logic [1:0] IDX_A = 2'd0;
   localparam logic [1:0] IDX_B = 2'd1;
   localparam logic [1:0] IDX_C = 2'd2;
   localparam logic [1:0] IDX_X = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRIVE_HI = 2'd1,
      ST_DRIVE_LO = 2'd2,
      ST_WAIT_RES = 2'd3
   } state_e;

   // All arithmetic stays 8 bits wide, so the truncation gives mod 256 directly.
   function automatic logic [DATA_W-1:0] poly_mod256(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] c,
      input logic [DATA_W-1:0] x
   );
      logic [DATA_W-1:0] x2_s;
      logic [DATA_W-1:0] ax2_s;
      logic [DATA_W-1:0] bx_s;
      x2_s  = x * x;
      ax2_s = a * x2_s;
      bx_s  = b * x;
      return ax2_s + bx_s + c;
   endfunction

endpackage

// File: rtl/poly_eval_ref_model.sv
// Combinational reference for (a*x*x + b*x + c) mod 256; only instantiated
// when the driver is built with POLY_EVAL_DRIVER_CHECK_EN.
module poly_eval_ref_model
   import poly_eval_driver_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] result
);

   assign result = poly_mod256(a, b, c, x);

endmodule

// File: rtl/poly_eval_driver.sv
// Drives A, B, C, X onto the evaluator with Go press/release, then collects the result.
// Optional result self-check: define POLY_EVAL_DRIVER_CHECK_EN to add the chk_err port.
module poly_eval_driver
   import poly_eval_driver_pkg::*;
#(
   parameter int GO_HI_CYCLES = 2,
   parameter int GO_LO_CYCLES = 2,
   parameter int TIMEOUT      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [DATA_W-1:0] req_c,
   input  logic [DATA_W-1:0] req_x,
   output logic [DATA_W-1:0] DataIn,
   output logic              Go,
   input  logic [DATA_W-1:0] DataResult,
   input  logic              ResultValid,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_timeout,
   output logic              busy
`ifdef POLY_EVAL_DRIVER_CHECK_EN
   ,
   output logic              chk_err
`endif
);

   localparam int MAX_HL = (GO_HI_CYCLES > GO_LO_CYCLES) ? GO_HI_CYCLES : GO_LO_CYCLES;
   localparam int MAX_P  = (MAX_HL > TIMEOUT) ? MAX_HL : TIMEOUT;
   localparam int CNT_W  = $clog2(MAX_P) + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(GO_HI_CYCLES - 1);
   localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(GO_LO_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

   state_e            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [1:0]        idx_r;
   logic [DATA_W-1:0] opnd_a_r;
   logic [DATA_W-1:0] opnd_b_r;
   logic [DATA_W-1:0] opnd_c_r;
   logic [DATA_W-1:0] opnd_x_r;
   logic              go_r;
   logic [DATA_W-1:0] data_in_r;
   logic              rsp_valid_r;
   logic [DATA_W-1:0] rsp_data_r;
   logic              rsp_timeout_r;
   logic              busy_r;
   logic              ready_r;
   logic [1:0]        idx_nxt_s;
   logic [DATA_W-1:0] next_opnd_s;
   logic              res_mismatch_s;

`ifdef POLY_EVAL_DRIVER_CHECK_EN
   logic [DATA_W-1:0] model_s;
   logic              chk_err_r;

   poly_eval_ref_model u_ref_model (
      .a      (opnd_a_r),
      .b      (opnd_b_r),
      .c      (opnd_c_r),
      .x      (opnd_x_r),
      .result (model_s)
   );

   assign res_mismatch_s = (DataResult != model_s);
   assign chk_err        = chk_err_r;
`else
   assign res_mismatch_s = 1'b0;
`endif

   // Operand that goes onto DataIn when stepping to the next index.
   always_comb begin
      idx_nxt_s   = idx_r + 2'd1;
      next_opnd_s = DATA_ZERO;
      case (idx_nxt_s)
         IDX_A:   next_opnd_s = opnd_a_r;
         IDX_B:   next_opnd_s = opnd_b_r;
         IDX_C:   next_opnd_s = opnd_c_r;
         IDX_X:   next_opnd_s = opnd_x_r;
         default: next_opnd_s = DATA_ZERO;
      endcase
   end

   // Transaction FSM with its counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         cnt_r         <= CNT_ZERO;
         idx_r         <= IDX_A;
         opnd_a_r      <= DATA_ZERO;
         opnd_b_r      <= DATA_ZERO;
         opnd_c_r      <= DATA_ZERO;
         opnd_x_r      <= DATA_ZERO;
         go_r          <= 1'b0;
         data_in_r     <= DATA_ZERO;
         rsp_valid_r   <= 1'b0;
         rsp_data_r    <= DATA_ZERO;
         rsp_timeout_r <= 1'b0;
         busy_r        <= 1'b0;
         ready_r       <= 1'b1;
`ifdef POLY_EVAL_DRIVER_CHECK_EN
         chk_err_r     <= 1'b0;
`endif
      end else begin
         rsp_valid_r   <= 1'b0;
         rsp_timeout_r <= 1'b0;
`ifdef POLY_EVAL_DRIVER_CHECK_EN
         chk_err_r     <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
               if (req_valid && ready_r) begin
                  opnd_a_r  <= req_a;
                  opnd_b_r  <= req_b;
                  opnd_c_r  <= req_c;
                  opnd_x_r  <= req_x;
                  idx_r     <= IDX_A;
                  cnt_r     <= CNT_ZERO;
                  data_in_r <= req_a;
                  go_r      <= 1'b1;
                  ready_r   <= 1'b0;
                  busy_r    <= 1'b1;
                  state_r   <= ST_DRIVE_HI;
               end
            end
            ST_DRIVE_HI: begin
               if (cnt_r == HI_LAST) begin
                  cnt_r   <= CNT_ZERO;
                  go_r    <= 1'b0;
                  state_r <= ST_DRIVE_LO;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_DRIVE_LO: begin
               if (cnt_r == LO_LAST) begin
                  cnt_r <= CNT_ZERO;
                  if (idx_r == IDX_X) begin
                     state_r <= ST_WAIT_RES;
                  end else begin
                     idx_r     <= idx_nxt_s;
                     data_in_r <= next_opnd_s;
                     go_r      <= 1'b1;
                     state_r   <= ST_DRIVE_HI;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_WAIT_RES: begin
               // A valid result takes priority over a timeout in the same cycle.
               if (ResultValid) begin
                  rsp_data_r  <= DataResult;
                  rsp_valid_r <= 1'b1;
`ifdef POLY_EVAL_DRIVER_CHECK_EN
                  chk_err_r   <= res_mismatch_s;
`endif
                  ready_r     <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else if (cnt_r == TO_LAST) begin
                  rsp_timeout_r <= 1'b1;
                  ready_r       <= 1'b1;
                  busy_r        <= 1'b0;
                  state_r       <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               go_r    <= 1'b0;
               cnt_r   <= CNT_ZERO;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = ready_r;
   assign DataIn      = data_in_r;
   assign Go          = go_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_data    = rsp_data_r;
   assign rsp_timeout = rsp_timeout_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_poly_eval_driver.sv
// Directed bench for poly_eval_driver against a behavioural evaluator stub.
module tb_poly_eval_driver;
   import poly_eval_driver_pkg::*;

   localparam int HI = 2;
   localparam int LO = 2;
   localparam int TO = 32;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      logic [7:0] x;
      logic [1:0] mode;      // 0 normal evaluator, 1 never valid, 2 returns 0xFF
      logic [7:0] exp_data;
      logic       exp_to;
      logic       exp_chk;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_a = 8'd0, req_b = 8'd0, req_c = 8'd0, req_x = 8'd0;
   logic [7:0] DataIn;
   logic       Go;
   logic [7:0] DataResult;
   logic       ResultValid;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_timeout;
   logic       busy;
`ifdef POLY_EVAL_DRIVER_CHECK_EN
   logic       chk_err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   vec_t vecs [9];

   always #5 clk = ~clk;

   poly_eval_driver #(.GO_HI_CYCLES(HI), .GO_LO_CYCLES(LO), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_c       (req_c),
      .req_x       (req_x),
      .DataIn      (DataIn),
      .Go          (Go),
      .DataResult  (DataResult),
      .ResultValid (ResultValid),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_timeout (rsp_timeout),
      .busy        (busy)
`ifdef POLY_EVAL_DRIVER_CHECK_EN
      ,
      .chk_err     (chk_err)
`endif
   );

   // Evaluator stub: samples DataIn on the first edge that sees Go, computes for 6 cycles.
   logic [1:0] ev_mode = 2'd0;
   logic       ev_go_q;
   logic [1:0] ev_idx;
   logic [7:0] ev_op [4];
   logic [3:0] ev_tmr;
   logic       ev_run;
   logic [7:0] ev_x2, ev_ax2, ev_bx, ev_res;

   always_comb begin
      ev_x2  = ev_op[3] * ev_op[3];
      ev_ax2 = ev_op[0] * ev_x2;
      ev_bx  = ev_op[1] * ev_op[3];
      ev_res = ev_ax2 + ev_bx + ev_op[2];
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev_go_q     <= 1'b0;
         ev_idx      <= 2'd0;
         ev_tmr      <= 4'd0;
         ev_run      <= 1'b0;
         ResultValid <= 1'b0;
         DataResult  <= 8'd0;
         for (int i = 0; i < 4; i++) ev_op[i] <= 8'd0;
      end else begin
         ev_go_q <= Go;
         if (Go && !ev_go_q) begin
            ev_op[ev_idx] <= DataIn;
            ev_idx        <= ev_idx + 2'd1;
            if (ev_idx == 2'd0) ResultValid <= 1'b0;
            if (ev_idx == 2'd3) begin
               ev_run <= 1'b1;
               ev_tmr <= 4'd6;
            end
         end else if (ev_run) begin
            if (ev_tmr == 4'd1) begin
               ev_run <= 1'b0;
               if (ev_mode != 2'd1) begin
                  ResultValid <= 1'b1;
                  DataResult  <= (ev_mode == 2'd2) ? 8'hFF : ev_res;
               end
            end else begin
               ev_tmr <= ev_tmr - 4'd1;
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_req", 32'(req_ready), 32'd1);
   endtask

   task automatic wait_rsp_valid(output bit seen);
      int n = 0;
      seen = 1'b0;
      while (n < 150) begin
         @(negedge clk);
         n++;
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("rsp_valid_seen", 32'(seen), 32'd1);
   endtask

   task automatic run_txn(input vec_t v, input int id);
      logic [7:0] ops [4];
      int  k, rises;
      int  rise_k [4];
      int  hi_len [4];
      logic go_prev;
      bit  done;
      ops[0] = v.a; ops[1] = v.b; ops[2] = v.c; ops[3] = v.x;
      wait_ready();
      ev_mode   = v.mode;
      req_a     = v.a;
      req_b     = v.b;
      req_c     = v.c;
      req_x     = v.x;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      k = 1; rises = 0; go_prev = 1'b0; done = 1'b0;
      for (int i = 0; i < 4; i++) begin rise_k[i] = 0; hi_len[i] = 0; end
      while (!done && k <= 120) begin
         if (Go && !go_prev) begin
            if (rises < 4) begin
               rise_k[rises] = k;
               check($sformatf("v%0d_datain_op%0d", id, rises), 32'(DataIn), 32'(ops[rises]));
            end
            rises++;
         end
         if (Go && rises >= 1 && rises <= 4) hi_len[rises-1]++;
         if (rsp_valid || rsp_timeout) done = 1'b1;
         go_prev = Go;
         if (!done) begin
            @(negedge clk);
            k++;
         end
      end
      check($sformatf("v%0d_resp_seen", id), 32'(done), 32'd1);
      check($sformatf("v%0d_go_pulses", id), 32'(rises), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("v%0d_rise_pos%0d", id, i), 32'(rise_k[i]), 32'(1 + i*(HI+LO)));
         check($sformatf("v%0d_hi_len%0d", id, i), 32'(hi_len[i]), 32'(HI));
      end
      check($sformatf("v%0d_rsp_valid", id), 32'(rsp_valid), 32'(!v.exp_to));
      check($sformatf("v%0d_rsp_timeout", id), 32'(rsp_timeout), 32'(v.exp_to));
      check($sformatf("v%0d_rsp_data", id), 32'(rsp_data), 32'(v.exp_data));
      check($sformatf("v%0d_busy_at_rsp", id), 32'(busy), 32'd0);
      if (v.exp_to) check($sformatf("v%0d_timeout_cycle", id), 32'(k), 32'(4*(HI+LO) + TO + 1));
`ifdef POLY_EVAL_DRIVER_CHECK_EN
      check($sformatf("v%0d_chk_err", id), 32'(chk_err), 32'(v.exp_chk && !v.exp_to));
`endif
      @(negedge clk);
      check($sformatf("v%0d_valid_drop", id), 32'(rsp_valid), 32'd0);
      check($sformatf("v%0d_timeout_drop", id), 32'(rsp_timeout), 32'd0);
      check($sformatf("v%0d_ready_after", id), 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit   seen;
      int   rises;
      logic go_prev;

      vecs[0] = '{8'd1,   8'd2,   8'd3,   8'd4,   2'd0, 8'd27,  1'b0, 1'b0};
      vecs[1] = '{8'd3,   8'd5,   8'd7,   8'd10,  2'd0, 8'd101, 1'b0, 1'b0};
      vecs[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 2'd0, 8'd255, 1'b0, 1'b0};
      vecs[3] = '{8'd2,   8'd0,   8'd0,   8'd16,  2'd0, 8'd0,   1'b0, 1'b0};
      vecs[4] = '{8'd7,   8'd0,   8'd1,   8'd3,   2'd0, 8'd64,  1'b0, 1'b0};
      vecs[5] = '{8'd0,   8'd1,   8'd0,   8'd200, 2'd0, 8'd200, 1'b0, 1'b0};
      vecs[6] = '{8'd9,   8'd9,   8'd9,   8'd9,   2'd1, 8'd200, 1'b1, 1'b0};
      vecs[7] = '{8'd1,   8'd2,   8'd3,   8'd4,   2'd2, 8'hFF,  1'b0, 1'b1};
      vecs[8] = '{8'd1,   8'd2,   8'd3,   8'd4,   2'd0, 8'd27,  1'b0, 1'b0};

      repeat (3) @(negedge clk);
      check("rst_go", 32'(Go), 32'd0);
      check("rst_datain", 32'(DataIn), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
`ifdef POLY_EVAL_DRIVER_CHECK_EN
      check("rst_chk_err", 32'(chk_err), 32'd0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

      // Back-to-back requests with req_valid held across the first response.
      ev_mode = 2'd0;
      wait_ready();
      req_a = 8'd1; req_b = 8'd2; req_c = 8'd3; req_x = 8'd4;
      req_valid = 1'b1;
      @(negedge clk);
      check("b2b_busy_first", 32'(busy), 32'd1);
      check("b2b_ready_low", 32'(req_ready), 32'd0);
      req_a = 8'd0; req_b = 8'd0; req_c = 8'd5; req_x = 8'd9;
      wait_rsp_valid(seen);
      check("b2b_data_first", 32'(rsp_data), 32'd27);
      check("b2b_ready_at_rsp", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("b2b_second_accepted", 32'(busy), 32'd1);
      check("b2b_second_ready_low", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      wait_rsp_valid(seen);
      check("b2b_data_second", 32'(rsp_data), 32'd5);

      // Reset asserted while operand C is being driven.
      wait_ready();
      req_a = 8'd1; req_b = 8'd2; req_c = 8'd3; req_x = 8'd4;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      rises = 0; go_prev = 1'b0;
      for (int n = 0; n < 40 && rises < 3; n++) begin
         if (Go && !go_prev) rises++;
         go_prev = Go;
         if (rises < 3) @(negedge clk);
      end
      check("mid_reached_c", 32'(rises), 32'd3);
      check("mid_datain_c", 32'(DataIn), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_go", 32'(Go), 32'd0);
      check("mid_rst_datain", 32'(DataIn), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_txn(vecs[0], 100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
